// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler for UART_rs232_tx: arbitrates two byte streams with packet locking,
// sequences the TxEn/TxDone handshake, generates the 16x Tick and aborts hung frames.
module uart_tx_sched #(
  parameter int unsigned TICK_DIV = 27,
  parameter int unsigned TIMEOUT  = 65535,
  parameter int unsigned NBITS    = 8
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       TxEn,
  output logic [7:0] TxData,
  output logic [3:0] NBits,
  output logic       Tick,
  input  logic       TxDone,
  output logic [1:0] grant,
  output logic       busy,
  output logic       err_timeout
);

  localparam int unsigned TickW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
  localparam logic [TickW-1:0] TickPre = TickW'(TICK_DIV - 2);
  localparam logic [16:0] WdLimit = 17'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSetup, StAssert, StDrop} state_e;

  state_e           state;
  logic [TickW-1:0] tick_cnt;
  logic [16:0]      wd_cnt;
  logic             last_grant;
  logic             lock_valid;
  logic             lock_owner;

  logic cand0, cand1, pick1, wd_hit;
  logic [7:0] sel_data;
  logic       sel_last;

  assign NBits = 4'(NBITS);

  // Tick is registered one cycle early so that it is high while the counter sits at TICK_DIV-1.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tick_cnt <= '0;
      Tick     <= 1'b0;
    end else begin
      tick_cnt <= (tick_cnt == TickMax) ? '0 : tick_cnt + TickW'(1);
      Tick     <= (tick_cnt == TickPre);
    end
  end

  assign cand0    = req0_valid && (!lock_valid || !lock_owner);
  assign cand1    = req1_valid && (!lock_valid || lock_owner);
  assign pick1    = cand1 && (!cand0 || !last_grant);
  assign sel_data = grant[1] ? req1_data : req0_data;
  assign sel_last = grant[1] ? req1_last : req0_last;
  assign wd_hit   = (wd_cnt == WdLimit);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= StIdle;
      grant       <= 2'b00;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      TxEn        <= 1'b0;
      TxData      <= 8'h00;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      last_grant  <= 1'b1;
      lock_valid  <= 1'b0;
      lock_owner  <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cand0 || cand1) begin
            state      <= StLoad;
            busy       <= 1'b1;
            grant      <= pick1 ? 2'b10 : 2'b01;
            req0_ready <= !pick1;
            req1_ready <= pick1;
          end
        end
        StLoad: begin
          TxData     <= sel_data;
          last_grant <= grant[1];
          lock_valid <= !sel_last;
          lock_owner <= grant[1];
          state      <= StSetup;
        end
        StSetup: begin
          state  <= StAssert;
          TxEn   <= 1'b1;
          wd_cnt <= '0;
        end
        StAssert: begin
          if (TxDone) begin
            state  <= StDrop;
            TxEn   <= 1'b0;
            wd_cnt <= '0;
          end else if (wd_hit) begin
            state       <= StIdle;
            TxEn        <= 1'b0;
            grant       <= 2'b00;
            busy        <= 1'b0;
            lock_valid  <= 1'b0;
            err_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 17'd1;
          end
        end
        StDrop: begin
          if (!TxDone) begin
            state <= StIdle;
            grant <= 2'b00;
            busy  <= 1'b0;
          end else if (wd_hit) begin
            state       <= StIdle;
            grant       <= 2'b00;
            busy        <= 1'b0;
            lock_valid  <= 1'b0;
            err_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 17'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised and directed bench for uart_tx_sched: bench clients, a TxDone responder and a
// transaction-level arbitration model that predicts the transmitted byte order.
module tb_uart_tx_sched;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       TxEn, Tick, TxDone, busy, err_timeout;
  logic [7:0] TxData;
  logic [3:0] NBits;
  logic [1:0] grant;

  uart_tx_sched #(.TICK_DIV(27), .TIMEOUT(100), .NBITS(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last),
    .req1_ready(req1_ready),
    .TxEn(TxEn), .TxData(TxData), .NBits(NBits), .Tick(Tick), .TxDone(TxDone),
    .grant(grant), .busy(busy), .err_timeout(err_timeout)
  );

  initial forever #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [8:0] q0[$], q1[$], m0[$], m1[$];   // {last, data}
  logic [9:0] exp_q[$];                    // {grant, data}
  int model_last = 1;
  int r0_cnt = 0, r1_cnt = 0, v0_rise_cyc = 0;
  int assert_cyc = 0, txen_fall_cyc = 0, done_rise_cyc = 0, done_fall_cyc = 0;
  int busy_fall_cyc = 0, err_cnt = 0, err_cyc = 0, ntick = 0, tick_wide = 0, hold_bad = 0;
  int tick_cyc[4];
  logic err_txen = 1'b0, err_busy = 1'b0, stuck = 1'b0;

  initial begin : client0
    logic acc;
    req0_valid = 0; req0_data = 0; req0_last = 0;
    forever begin
      @(negedge Clk);
      acc = req0_ready;
      @(posedge Clk); #1;
      if (acc) begin
        r0_cnt++;
        if (q0.size() > 0) q0.delete(0);
      end
      if (q0.size() > 0) begin
        if (!req0_valid) v0_rise_cyc = cyc;
        req0_valid = 1'b1;
        {req0_last, req0_data} = q0[0];
      end else begin
        req0_valid = 1'b0;
      end
    end
  end

  initial begin : client1
    logic acc;
    req1_valid = 0; req1_data = 0; req1_last = 0;
    forever begin
      @(negedge Clk);
      acc = req1_ready;
      @(posedge Clk); #1;
      if (acc) begin
        r1_cnt++;
        if (q1.size() > 0) q1.delete(0);
      end
      if (q1.size() > 0) begin
        req1_valid = 1'b1;
        {req1_last, req1_data} = q1[0];
      end else begin
        req1_valid = 1'b0;
      end
    end
  end

  // Transmitter stand-in: raises TxDone a few cycles into a frame, drops it after TxEn falls.
  initial begin : responder
    int dly;
    TxDone = 1'b0;
    dly = $urandom_range(2, 6);
    forever begin
      @(posedge Clk); #2;
      if (TxEn && !TxDone && !stuck) begin
        if (dly == 0) begin
          TxDone = 1'b1; done_rise_cyc = cyc; dly = $urandom_range(0, 3);
        end else dly--;
      end else if (!TxEn && TxDone) begin
        if (dly == 0) begin
          TxDone = 1'b0; done_fall_cyc = cyc; dly = $urandom_range(2, 6);
        end else dly--;
      end
    end
  end

  initial begin : monitor
    logic txen_p, busy_p, tick_p, armed;
    logic [7:0] hold_data;
    logic [9:0] e;
    txen_p = 0; busy_p = 0; tick_p = 0; armed = 0; hold_data = 0;
    forever begin
      @(posedge Clk); #1;
      if (TxEn && !txen_p) begin
        assert_cyc = cyc;
        if (exp_q.size() == 0) check_eq("tx_unexpected", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check_eq("tx_data", TxData, e[7:0]);
          check_eq("tx_grant", grant, e[9:8]);
        end
      end
      if (!TxEn && txen_p) txen_fall_cyc = cyc;
      if (!busy && busy_p) busy_fall_cyc = cyc;
      if (err_timeout) begin
        err_cnt++; err_cyc = cyc; err_txen = TxEn; err_busy = busy;
      end
      if (Tick && ntick < 4) begin tick_cyc[ntick] = cyc; ntick++; end
      if (Tick && tick_p) tick_wide++;
      if ((TxEn || TxDone) && armed && TxData != hold_data) hold_bad++;
      hold_data = TxData;
      armed = TxEn || TxDone;
      txen_p = TxEn; busy_p = busy; tick_p = Tick;
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || q0.size() > 0 || q1.size() > 0 || busy || TxDone)
           && n < budget) begin
      @(posedge Clk); #4;
      n++;
    end
    check_eq("drain_left", exp_q.size() + q0.size() + q1.size(), 0);
  endtask

  // Packet-level arbitration: lock owner first, else alternate away from the last winner.
  task automatic run_model();
    int owner = -1;
    int pick;
    logic [8:0] e;
    while (m0.size() > 0 || m1.size() > 0) begin
      if (owner >= 0) pick = owner;
      else if (m0.size() > 0 && m1.size() > 0) pick = (model_last == 1) ? 0 : 1;
      else pick = (m0.size() > 0) ? 0 : 1;
      if (pick == 0) e = m0.pop_front();
      else e = m1.pop_front();
      exp_q.push_back({(pick == 1) ? 2'b10 : 2'b01, e[7:0]});
      model_last = pick;
      owner = e[8] ? -1 : pick;
    end
  endtask

  initial begin : main
    int base, n;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("rst_txen", TxEn, 0);
    check_eq("rst_txdata", TxData, 0);
    check_eq("rst_tick", Tick, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready0", req0_ready, 0);
    check_eq("rst_ready1", req1_ready, 0);
    check_eq("rst_err", err_timeout, 0);
    check_eq("nbits", NBits, 8);

    // Tick: high in the 27th cycle counted from release, then every 27 cycles
    Rst_n = 1'b1;
    base = cyc;
    ntick = 0;
    repeat (120) @(posedge Clk);
    #4;
    check_eq("tick_count", ntick, 4);
    check_eq("tick_first", tick_cyc[0] - base, 26);
    check_eq("tick_gap1", tick_cyc[1] - tick_cyc[0], 27);
    check_eq("tick_gap2", tick_cyc[2] - tick_cyc[1], 27);
    check_eq("tick_width", tick_wide, 0);

    // Simultaneous requests, last_grant=1 out of reset
    @(negedge Clk);
    q0.push_back({1'b1, 8'h10}); q0.push_back({1'b1, 8'h11});
    q1.push_back({1'b1, 8'h20}); q1.push_back({1'b1, 8'h21});
    exp_q.push_back({2'b01, 8'h10}); exp_q.push_back({2'b10, 8'h20});
    exp_q.push_back({2'b01, 8'h11}); exp_q.push_back({2'b10, 8'h21});
    wait_idle(500);
    model_last = 1;

    // Single byte
    base = r0_cnt;
    @(negedge Clk);
    q0.push_back({1'b1, 8'hA5});
    exp_q.push_back({2'b01, 8'hA5});
    wait_idle(200);
    model_last = 0;
    check_eq("single_ready_pulses", r0_cnt - base, 1);
    check_eq("single_txen_lat", assert_cyc - v0_rise_cyc, 3);
    check_eq("single_txen_fall", txen_fall_cyc - done_rise_cyc, 1);
    check_eq("single_busy_fall", busy_fall_cyc - done_fall_cyc, 1);

    // Packet lock
    base = r1_cnt;
    @(negedge Clk);
    q1.push_back({1'b0, 8'h31}); q1.push_back({1'b0, 8'h32}); q1.push_back({1'b1, 8'h33});
    exp_q.push_back({2'b10, 8'h31}); exp_q.push_back({2'b10, 8'h32});
    exp_q.push_back({2'b10, 8'h33}); exp_q.push_back({2'b01, 8'h44});
    n = 0;
    while (r1_cnt == base && n < 50) begin @(posedge Clk); #4; n++; end
    check_eq("lock_first_accept", r1_cnt - base, 1);
    @(negedge Clk);
    q0.push_back({1'b1, 8'h44});
    base = r0_cnt;
    n = 0;
    while (r1_cnt < base + 0 + 3 - 0 && 0 == 1) n++;
    n = 0;
    while (q1.size() > 0 && n < 200) begin @(posedge Clk); #4; n++; end
    check_eq("lock_r0_held", r0_cnt - base, 0);
    wait_idle(300);
    model_last = 0;

    // Watchdog
    stuck = 1'b1;
    base = err_cnt;
    @(negedge Clk);
    q0.push_back({1'b1, 8'h77});
    exp_q.push_back({2'b01, 8'h77});
    n = 0;
    while (err_cnt == base && n < 300) begin @(posedge Clk); #4; n++; end
    check_eq("wd_fired", err_cnt - base, 1);
    check_eq("wd_delay", err_cyc - assert_cyc, 100);
    check_eq("wd_txen", err_txen, 0);
    check_eq("wd_busy", err_busy, 0);
    repeat (3) @(posedge Clk);
    #4;
    check_eq("wd_pulses", err_cnt - base, 1);
    stuck = 1'b0;
    @(negedge Clk);
    q0.push_back({1'b1, 8'h78});
    exp_q.push_back({2'b01, 8'h78});
    wait_idle(200);
    model_last = 0;

    // Randomised packets on both clients, order predicted by the model
    for (int r = 0; r < 4; r++) begin
      @(negedge Clk);
      for (int c = 0; c < 2; c++) begin
        int np;
        np = $urandom_range(1, 3);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) begin
            logic [8:0] e;
            e = {(b == len - 1), 8'($urandom)};
            if (c == 0) begin q0.push_back(e); m0.push_back(e); end
            else begin q1.push_back(e); m1.push_back(e); end
          end
        end
      end
      run_model();
      wait_idle(3000);
    end

    // Reset in ASSERT while req0 holds a lock
    stuck = 1'b1;
    @(negedge Clk);
    q0.push_back({1'b0, 8'h66});
    exp_q.push_back({2'b01, 8'h66});
    n = 0;
    while (!TxEn && n < 50) begin @(posedge Clk); #4; n++; end
    check_eq("mid_txen_seen", TxEn, 1);
    #3;
    Rst_n = 1'b0;
    #1;
    check_eq("mid_txen", TxEn, 0);
    check_eq("mid_grant", grant, 0);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_tick", Tick, 0);
    check_eq("mid_ready0", req0_ready, 0);
    check_eq("mid_ready1", req1_ready, 0);
    q0.delete();
    q1.delete();
    stuck = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    @(negedge Clk);
    q1.push_back({1'b1, 8'h5A});
    exp_q.push_back({2'b10, 8'h5A});
    wait_idle(200);

    check_eq("txdata_hold", hold_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
